// File: rtl/cache_controller.sv
// Two-way set-associative write-through data cache between MEM stage and SRAM controller.
// Latency: read hit 0 cycles (combinational); miss or write 1 + N cycles (N = SRAM latency).
// Backpressure: ready held low in S_READ/S_WRITE until sramReady; requester holds inputs until ready.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   address, writeData       request from MEM stage (byte address, store data)
//   wrEn, rdEn               store / load request (store wins when both set)
//   readData, ready          load result (0 unless a read completes), completion flag
//   sramAddress/WriteData    pass-through of address/writeData to SRAM controller
//   sramWrEn, sramRdEn       registered SRAM strobes, never both high
//   sramReadData, sramReady  64-bit block (even word in [31:0]) and 1-cycle done pulse
//
// Build option: define CACHE_EN for the full cache; without it there is no storage
// and every read is serviced through S_READ.
module cache_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        wrEn,
  input  logic        rdEn,
  output logic [31:0] readData,
  output logic        ready,
  output logic [31:0] sramAddress,
  output logic [31:0] sramWriteData,
  output logic        sramWrEn,
  output logic        sramRdEn,
  input  logic [63:0] sramReadData,
  input  logic        sramReady
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        rd_strobe;
  logic        wr_strobe;

  // Data memory is mapped starting at byte 1024.
  logic [31:0] ea;
  logic        word_sel;
  logic        fill_done;
  logic        write_done;
  logic [31:0] fill_word;
  logic        hit;
  logic [31:0] hit_word;

  assign ea         = address - 32'd1024;
  assign word_sel   = ea[2];
  assign fill_done  = (state == S_READ) && sramReady;
  assign write_done = (state == S_WRITE) && sramReady;
  assign fill_word  = word_sel ? sramReadData[63:32] : sramReadData[31:0];

`ifdef CACHE_EN
  logic [5:0]  idx;
  logic [9:0]  tag;
  logic [63:0] valid_mem [2];
  logic [9:0]  tag_mem   [2][64];
  logic [63:0] data_mem  [2][64];
  logic [63:0] lru;                 // per set: way that was used least recently
  logic        hit0;
  logic        hit1;
  logic        hit_way;
  logic        victim;
  logic        read_hit;
  logic [63:0] hit_line;
  logic        unused_ea_bits;

  assign idx            = ea[8:3];
  assign tag            = ea[18:9];
  assign unused_ea_bits = ^{ea[31:19], ea[1:0]};

  assign hit0     = valid_mem[0][idx] && (tag_mem[0][idx] == tag);
  assign hit1     = valid_mem[1][idx] && (tag_mem[1][idx] == tag);
  assign hit      = hit0 || hit1;
  assign hit_way  = hit1;
  assign hit_line = data_mem[hit_way][idx];
  assign hit_word = word_sel ? hit_line[63:32] : hit_line[31:0];
  assign read_hit = (state == S_IDLE) && rdEn && !wrEn && hit;

  // Fill an empty way before displacing anything; way 0 is preferred.
  always_comb begin
    victim = lru[idx];
    if (!valid_mem[0][idx]) begin
      victim = 1'b0;
    end else if (!valid_mem[1][idx]) begin
      victim = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < 2; w++) begin
        valid_mem[w] <= '0;
        for (int s = 0; s < 64; s++) begin
          tag_mem[w][s] <= '0;
        end
      end
      lru <= '0;
    end else begin
      if (read_hit) begin
        lru[idx] <= ~hit_way;
      end
      if (fill_done) begin
        valid_mem[victim][idx] <= 1'b1;
        tag_mem[victim][idx]   <= tag;
        lru[idx]               <= ~victim;
      end
      if (write_done && hit) begin
        lru[idx] <= ~hit_way;
      end
    end
  end

  // Line data carries no reset; a line is only observed once its valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_done) begin
        data_mem[victim][idx] <= sramReadData;
      end else if (write_done && hit) begin
        if (word_sel) begin
          data_mem[hit_way][idx][63:32] <= writeData;
        end else begin
          data_mem[hit_way][idx][31:0] <= writeData;
        end
      end
    end
  end
`else
  logic unused_ea_bits;

  assign hit            = 1'b0;
  assign hit_word       = 32'd0;
  assign unused_ea_bits = ^{ea[31:3], ea[1:0]};
`endif

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    readData  = 32'd0;
    case (state)
      S_IDLE: begin
        if (wrEn) begin
          state_nxt = S_WRITE;
        end else if (rdEn) begin
          if (hit) begin
            ready    = 1'b1;
            readData = hit_word;
          end else begin
            state_nxt = S_READ;
          end
        end else begin
          ready = 1'b1;
        end
      end
      S_READ: begin
        if (sramReady) begin
          ready     = 1'b1;
          readData  = fill_word;
          state_nxt = S_IDLE;
        end
      end
      S_WRITE: begin
        if (sramReady) begin
          ready     = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes follow the state being entered, so they rise on entry and fall on
  // the edge after sramReady.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rd_strobe <= 1'b0;
      wr_strobe <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_strobe <= (state_nxt == S_READ);
      wr_strobe <= (state_nxt == S_WRITE);
    end
  end

  assign sramAddress   = address;
  assign sramWriteData = writeData;
  assign sramRdEn      = rd_strobe;
  assign sramWrEn      = wr_strobe;

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: an SRAM responder with configurable latency, a word-level
// memory image, and a timestamp-based two-way cache model deciding which reads hit.
module tb_cache_controller;

  logic        clk;
  logic        rst;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        wrEn;
  logic        rdEn;
  logic [31:0] readData;
  logic        ready;
  logic [31:0] sramAddress;
  logic [31:0] sramWriteData;
  logic        sramWrEn;
  logic        sramRdEn;
  logic [63:0] sramReadData;
  logic        sramReady;

  int checks = 0;
  int errors = 0;

  cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .writeData    (writeData),
    .wrEn         (wrEn),
    .rdEn         (rdEn),
    .readData     (readData),
    .ready        (ready),
    .sramAddress  (sramAddress),
    .sramWriteData(sramWriteData),
    .sramWrEn     (sramWrEn),
    .sramRdEn     (sramRdEn),
    .sramReadData (sramReadData),
    .sramReady    (sramReady)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- SRAM memory image and responder ----------------
  logic [31:0] mem [int unsigned];
  int fixed_lat = 0;   // 0: random latency 1..4
  int last_lat  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int unsigned k;
    k = a >> 2;
    if (mem.exists(k)) return mem[k];
    return (k * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  initial begin
    int  cnt;
    bit  busy;
    logic [31:0] base;
    sramReady    = 1'b0;
    sramReadData = '0;
    busy         = 1'b0;
    cnt          = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        sramReady = 1'b0;
        busy      = 1'b0;
      end else if (sramReady) begin
        sramReady    = 1'b0;
        sramReadData = '0;
        busy         = 1'b0;
      end else if (sramRdEn || sramWrEn) begin
        if (!busy) begin
          busy     = 1'b1;
          last_lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
          cnt      = last_lat - 1;
        end
        if (cnt == 0) begin
          sramReady = 1'b1;
          if (sramWrEn) begin
            mem[sramAddress >> 2] = sramWriteData;
          end else begin
            base         = sramAddress & ~32'd7;
            sramReadData = {mem_word(base + 32'd4), mem_word(base)};
          end
        end else begin
          cnt--;
        end
      end
    end
  end

  // ---------------- Cache reference model ----------------
  // Each line remembers when it was last touched; the older line of a full set is evicted.
  bit          m_valid [64][2];
  logic [9:0]  m_tag   [64][2];
  int          m_stamp [64][2];
  int          m_now;

  function automatic void m_reset();
    for (int s = 0; s < 64; s++) begin
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_tag[s][w]   = '0;
        m_stamp[s][w] = 0;
      end
    end
    m_now = 0;
  endfunction

  function automatic int m_lookup(input logic [31:0] a);
`ifdef CACHE_EN
    logic [31:0] e;
    int s;
    e = a - 32'd1024;
    s = int'(e[8:3]);
    for (int w = 0; w < 2; w++) begin
      if (m_valid[s][w] && m_tag[s][w] == e[18:9]) return w;
    end
`endif
    return -1;
  endfunction

  function automatic void m_read(input logic [31:0] a);
    logic [31:0] e;
    int s;
    int w;
    e = a - 32'd1024;
    s = int'(e[8:3]);
    w = m_lookup(a);
    m_now++;
    if (w < 0) begin
      if (!m_valid[s][0]) w = 0;
      else if (!m_valid[s][1]) w = 1;
      else w = (m_stamp[s][0] < m_stamp[s][1]) ? 0 : 1;
      m_valid[s][w] = 1'b1;
      m_tag[s][w]   = e[18:9];
    end
    m_stamp[s][w] = m_now;
  endfunction

  function automatic void m_write(input logic [31:0] a);
    logic [31:0] e;
    int s;
    int w;
    e = a - 32'd1024;
    s = int'(e[8:3]);
    w = m_lookup(a);
    m_now++;
    if (w >= 0) m_stamp[s][w] = m_now;
  endfunction

  // ---------------- Request driver ----------------
  // Holds the request until ready, collecting strobe activity and protocol violations.
  task automatic do_access(input logic [31:0] a, input logic [31:0] wd, input bit we, input bit re,
                           output logic [31:0] rd, output int cyc, output bit saw_rd,
                           output bit saw_wr, output bit bad);
    @(negedge clk);
    address   = a;
    writeData = wd;
    wrEn      = we;
    rdEn      = re;
    #1;
    cyc = 0; saw_rd = 1'b0; saw_wr = 1'b0; bad = 1'b0; rd = '0;
    forever begin
      saw_rd |= (sramRdEn === 1'b1);
      saw_wr |= (sramWrEn === 1'b1);
      if (sramRdEn === 1'b1 && sramWrEn === 1'b1) bad = 1'b1;
      if (sramAddress !== a || sramWriteData !== wd) bad = 1'b1;
      if (ready === 1'b1) break;
      if (readData !== 32'd0) bad = 1'b1;
      if (cyc >= 60) begin
        bad = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
      cyc++;
    end
    rd = readData;
    @(posedge clk);
    #1;
    wrEn = 1'b0;
    rdEn = 1'b0;
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    rst = 1'b1; wrEn = 1'b0; rdEn = 1'b0; address = 32'd1024; writeData = '0;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b1)     begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (sramRdEn !== 1'b0)  begin errors++; $display("FAIL reset_rden: got %b expected 0", sramRdEn); end
    checks++; if (sramWrEn !== 1'b0)  begin errors++; $display("FAIL reset_wren: got %b expected 0", sramWrEn); end
    checks++; if (readData !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", readData); end
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_read_miss_hit();
    logic [31:0] rd; int cyc; bit sr, sw, bad; bit eh;
    mem[32'd1024 >> 2] = 32'hDEAD_BEEF;
    fixed_lat = 3;
    m_read(32'd1024);
    do_access(32'd1024, 32'd0, 1'b0, 1'b1, rd, cyc, sr, sw, bad);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_data: got %h expected deadbeef", rd); end
    checks++; if (cyc !== 3)  begin errors++; $display("FAIL miss_latency: got %0d expected 3", cyc); end
    checks++; if (sr !== 1'b1 || sw !== 1'b0) begin errors++; $display("FAIL miss_strobes: rd %b wr %b expected 1 0", sr, sw); end
    checks++; if (bad) begin errors++; $display("FAIL miss_protocol: violation seen expected none"); end
    fixed_lat = 0;
    eh = (m_lookup(32'd1024) >= 0);
    m_read(32'd1024);
    do_access(32'd1024, 32'd0, 1'b0, 1'b1, rd, cyc, sr, sw, bad);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reread_data: got %h expected deadbeef", rd); end
    checks++; if ((cyc == 0) !== eh) begin errors++; $display("FAIL reread_hit: cycles %0d expected hit %b", cyc, eh); end
    checks++; if (sr !== !eh) begin errors++; $display("FAIL reread_rden: got %b expected %b", sr, !eh); end
  endtask

  task automatic test_upper_word();
    logic [31:0] rd; int cyc; bit sr, sw, bad; bit eh; logic [31:0] exp;
    exp = mem_word(32'd1028);
    eh  = (m_lookup(32'd1028) >= 0);
    m_read(32'd1028);
    do_access(32'd1028, 32'd0, 1'b0, 1'b1, rd, cyc, sr, sw, bad);
    checks++; if (rd !== exp) begin errors++; $display("FAIL upper_data: got %h expected %h", rd, exp); end
    checks++; if ((cyc == 0) !== eh) begin errors++; $display("FAIL upper_hit: cycles %0d expected hit %b", cyc, eh); end
  endtask

  task automatic test_lru_evict();
    logic [31:0] seq [5];
    logic [31:0] rd; int cyc; bit sr, sw, bad; bit eh; logic [31:0] exp;
    seq = '{32'd1024, 32'd1536, 32'd2048, 32'd1536, 32'd1024};
    foreach (seq[i]) begin
      exp = mem_word(seq[i]);
      eh  = (m_lookup(seq[i]) >= 0);
      m_read(seq[i]);
      do_access(seq[i], 32'd0, 1'b0, 1'b1, rd, cyc, sr, sw, bad);
      checks++; if (rd !== exp) begin errors++; $display("FAIL lru_data[%0d]: got %h expected %h", i, rd, exp); end
      checks++; if ((cyc == 0) !== eh || sr !== !eh) begin
        errors++; $display("FAIL lru_hit[%0d]: cycles %0d rden %b expected hit %b", i, cyc, sr, eh);
      end
    end
  endtask

  task automatic test_write_hit();
    logic [31:0] rd; int cyc; bit sr, sw, bad; bit eh;
    m_read(32'd1024);
    do_access(32'd1024, 32'd0, 1'b0, 1'b1, rd, cyc, sr, sw, bad);
    fixed_lat = 2;
    m_write(32'd1024);
    do_access(32'd1024, 32'h1234_5678, 1'b1, 1'b0, rd, cyc, sr, sw, bad);
    checks++; if (sw !== 1'b1 || sr !== 1'b0) begin errors++; $display("FAIL write_strobes: rd %b wr %b expected 0 1", sr, sw); end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL write_latency: got %0d expected 2", cyc); end
    checks++; if (rd !== 32'd0 || bad) begin errors++; $display("FAIL write_rdata: got %h bad %b expected 0 0", rd, bad); end
    fixed_lat = 0;
    eh = (m_lookup(32'd1024) >= 0);
    m_read(32'd1024);
    do_access(32'd1024, 32'd0, 1'b0, 1'b1, rd, cyc, sr, sw, bad);
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL write_readback: got %h expected 12345678", rd); end
    checks++; if ((cyc == 0) !== eh) begin errors++; $display("FAIL write_readback_hit: cycles %0d expected hit %b", cyc, eh); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] rd; int cyc; bit sr, sw, bad;
    fixed_lat = 8;
    @(negedge clk);
    address = 32'd1024 + 32'd40; writeData = '0; rdEn = 1'b1; wrEn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (sramRdEn !== 1'b1 || ready !== 1'b0) begin
      errors++; $display("FAIL midread_busy: rden %b ready %b expected 1 0", sramRdEn, ready);
    end
    rst = 1'b1; rdEn = 1'b0;
    @(negedge clk);
    checks++; if (sramRdEn !== 1'b0 || sramWrEn !== 1'b0) begin
      errors++; $display("FAIL midread_strobes: rd %b wr %b expected 0 0", sramRdEn, sramWrEn);
    end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midread_ready: got %b expected 1", ready); end
    rst = 1'b0;
    m_reset();
    fixed_lat = 0;
    m_read(32'd1024);
    do_access(32'd1024, 32'd0, 1'b0, 1'b1, rd, cyc, sr, sw, bad);
    checks++; if (sr !== 1'b1 || cyc == 0) begin errors++; $display("FAIL midread_refill: rden %b cycles %0d expected miss", sr, cyc); end
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL midread_data: got %h expected 12345678", rd); end
  endtask

  task automatic test_write_nofill();
    logic [31:0] rd; int cyc; bit sr, sw, bad;
    m_write(32'd2048);
    do_access(32'd2048, 32'hCAFE_0001, 1'b1, 1'b0, rd, cyc, sr, sw, bad);
    checks++; if (sw !== 1'b1 || sr !== 1'b0 || bad) begin errors++; $display("FAIL nofill_write: rd %b wr %b bad %b expected 0 1 0", sr, sw, bad); end
    m_read(32'd2048);
    do_access(32'd2048, 32'd0, 1'b0, 1'b1, rd, cyc, sr, sw, bad);
    checks++; if (sr !== 1'b1 || cyc !== last_lat) begin errors++; $display("FAIL nofill_miss: rden %b cycles %0d expected 1 %0d", sr, cyc, last_lat); end
    checks++; if (rd !== 32'hCAFE_0001) begin errors++; $display("FAIL nofill_data: got %h expected cafe0001", rd); end
  endtask

  task automatic test_both_en();
    logic [31:0] rd; int cyc; bit sr, sw, bad; logic [31:0] exp;
    m_write(32'd2048);
    do_access(32'd2048, 32'h0BAD_F00D, 1'b1, 1'b1, rd, cyc, sr, sw, bad);
    checks++; if (sw !== 1'b1 || sr !== 1'b0) begin errors++; $display("FAIL both_strobes: rd %b wr %b expected 0 1", sr, sw); end
    checks++; if (rd !== 32'd0 || cyc !== last_lat) begin errors++; $display("FAIL both_done: rdata %h cycles %0d expected 0 %0d", rd, cyc, last_lat); end
    exp = mem_word(32'd2048);
    checks++; if (exp !== 32'h0BAD_F00D) begin errors++; $display("FAIL both_mem: got %h expected 0badf00d", exp); end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd, exp; int cyc; bit sr, sw, bad, we, eh;
    for (int i = 0; i < 200; i++) begin
      a  = 32'd1024 + ($urandom_range(0, 2) << 9) + ($urandom_range(0, 3) << 3) + ($urandom_range(0, 1) << 2);
      we = ($urandom_range(0, 9) < 3);
      if (we) begin
        wd = $urandom;
        m_write(a);
        do_access(a, wd, 1'b1, 1'($urandom_range(0, 1)), rd, cyc, sr, sw, bad);
        checks++; if (sw !== 1'b1 || sr !== 1'b0 || rd !== 32'd0 || cyc !== last_lat || bad) begin
          errors++; $display("FAIL rnd_write[%0d] a=%h: rd %b wr %b rdata %h cycles %0d bad %b expected 0 1 0 %0d 0",
                              i, a, sr, sw, rd, cyc, bad, last_lat);
        end
      end else begin
        exp = mem_word(a);
        eh  = (m_lookup(a) >= 0);
        m_read(a);
        do_access(a, 32'd0, 1'b0, 1'b1, rd, cyc, sr, sw, bad);
        checks++; if (rd !== exp) begin errors++; $display("FAIL rnd_rdata[%0d] a=%h: got %h expected %h", i, a, rd, exp); end
        checks++; if (cyc !== (eh ? 0 : last_lat) || sr !== !eh || sw !== 1'b0 || bad) begin
          errors++; $display("FAIL rnd_read[%0d] a=%h: cycles %0d rd %b wr %b bad %b expected hit %b",
                              i, a, cyc, sr, sw, bad, eh);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wrEn = 1'b0; rdEn = 1'b0; address = '0; writeData = '0;
    test_reset();
    test_read_miss_hit();
    test_upper_word();
    test_lru_evict();
    test_write_hit();
    test_reset_mid_read();
    test_write_nofill();
    test_both_en();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Two-way set-associative, write-through data cache between the MEM stage of the ARM pipeline and the SRAM controller. Read hits return data combinationally in the request cycle. Misses and all writes are forwarded to the SRAM controller, and `ready` is held low until that controller signals completion. Cache lines are 64-bit, matching the SRAM controller's two-word burst.

## Interface
Parameters: none.
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `address`  in  32  byte address from MEM stage
- `writeData`  in  32  store data
- `wrEn`  in  1  store request
- `rdEn`  in  1  load request
- `readData`  out  32  load result, 0 when no read completes
- `ready`  out  1  request complete / stage may advance
- `sramAddress`  out  32  address to SRAM controller, equal to `address`
- `sramWriteData`  out  32  equal to `writeData`
- `sramWrEn`  out  1  SRAM write request
- `sramRdEn`  out  1  SRAM 64-bit block read request
- `sramReadData`  in  64  block from SRAM; [31:0] is the even word, [63:32] the odd word
- `sramReady`  in  1  SRAM operation done, 1-cycle pulse

## Operation
- Effective address: `ea = address - 1024`. `ea[1:0]` ignored. `ea[2]` selects the word within the line. `ea[8:3]` is the set index (64 sets). `ea[18:9]` is the tag (10 bits).
- Per set and way: valid bit, 10-bit tag, 64-bit data. Per set: one LRU bit naming the least-recently-used way.
- Hit: valid and tag match in either way. Both ways matching cannot occur.
- Read hit: `readData` = selected word, `ready`=1, and the LRU bit points to the other way.
- Read miss: enter S_READ with `sramRdEn`=1. On `sramReady`, fill the victim way:
  - Victim is an invalid way if one exists (way 0 first), otherwise the LRU way.
  - Set valid, write the tag, update LRU.
  - `readData` = selected word of `sramReadData`, `ready`=1.
- Write (hit or miss): enter S_WRITE with `sramWrEn`=1 until `sramReady`; then `ready`=1. No allocate on miss.
  - On hit, the matching word is updated in the cache at the `sramReady` edge and LRU is updated.
- FSM states: S_IDLE, S_READ, S_WRITE.
  - From S_IDLE: `wrEn` → S_WRITE; `rdEn` and miss → S_READ; otherwise stay.
  - S_READ or S_WRITE with `sramReady` → S_IDLE.
- `wrEn` and `rdEn` both high: write takes priority, and the read is ignored.
- Requester holds `address`, `writeData`, `wrEn` and `rdEn` stable until `ready`.

## Timing
- Reset outputs: `ready`=1, `sramRdEn`=0, `sramWrEn`=0, `readData`=0. All valid bits, tags and LRU bits are cleared, and the state is S_IDLE.
- `ready` is combinational. It is 1 in S_IDLE with no request or on a read hit. It is 0 in S_READ and S_WRITE except in the cycle where `sramReady`=1.
- Read hit: 0 extra cycles. Miss or write: 1 + N cycles, where N is the SRAM controller latency; `ready` rises in the `sramReady` cycle.
- `sramRdEn` and `sramWrEn` are registered on entry to a state and drop on the edge after `sramReady`. They are never both high.
- Reset mid-operation: the pending SRAM transaction is abandoned, and the strobes are 0 from the first cycle after the reset edge.
- A new request is accepted in the cycle after completion; there is no back-to-back overlap.

## Configuration
- `CACHE_EN` defined: full cache as above.
- `CACHE_EN` undefined: no storage, every read is treated as a miss.
  - The read goes through S_READ and returns the SRAM word; writes are unchanged.
  - The interface and timing rules are otherwise identical.

## Test plan
- After reset, read 1024 with SRAM word 0xDEADBEEF → `sramRdEn`=1, `ready`=0 until `sramReady`, then `readData`=0xDEADBEEF. A repeat read of 1024 → hit, `ready`=1 same cycle, no `sramRdEn`.
- Read 1028 after filling 1024 → hit returns the upper word of the filled block.
- Reads of 1024, 1024+512, 1024+1024 (same set, three tags), then re-read 1024+512 → third read evicts the 1024 line (LRU); the re-read of 1024+512 hits.
- Write 0x12345678 to 1024 (cached) → `sramWrEn` until `sramReady`; a following read of 1024 hits with 0x12345678.
- Write to uncached 2048, then read 2048 → write causes no fill; the read misses.
- Assert `rst` during S_READ → strobes 0 next cycle, `ready`=1, and a subsequent read of 1024 misses.
